// File: rtl/sbox_pkg.sv
// Shared constants, FSM state type and ASCII helpers for the S-box UART transmit path.
// Build option: SBOX_TX_PREFIX_EN prepends an 'E'/'D' mode character to every frame.
package sbox_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_D  = 8'h44;

`ifdef SBOX_TX_PREFIX_EN
  localparam int unsigned NUM_CHARS = 5;
`else
  localparam int unsigned NUM_CHARS = 4;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] mode_char(input logic encrypt);
    return encrypt ? ASCII_E : ASCII_D;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte. Owns the baud and bit counters; `ready` lets the
// caller hand over the next byte on the last stop-bit cycle for gapless characters.
module uart_tx_byte
  import sbox_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST_BAUD = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (baud_q == LAST_BAUD);
  assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign tx      = tx_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          baud_d  = '0;
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          done_d = 1'b1;
          // Chaining straight into the next start bit keeps characters back to back.
          if (start) begin
            state_d = START;
            shreg_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      // NOTE: the shift register is reset as well; it is tiny and keeps the datapath free of X after reset.
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/sbox_uart_tx.sv
// Sends the S-box result byte as uppercase ASCII hex plus CR LF over an 8N1 UART.
// Build option: SBOX_TX_PREFIX_EN prepends 'E' (encrypt) or 'D' (decrypt) to each frame.
module sbox_uart_tx
  import sbox_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       encrypt,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam logic [2:0] LAST_CHAR = 3'(NUM_CHARS - 1);

  logic       busy_q, done_q;
  logic [2:0] char_idx;
  logic [7:0] data_q;
  logic       accept, more;
  logic       byte_start, byte_ready, byte_busy, byte_done;
  logic [7:0] byte_data;
  logic [2:0] sel_idx;
  logic [7:0] sel_byte;

  assign accept     = start && !busy_q && !byte_busy;
  assign more       = (char_idx != LAST_CHAR);
  assign byte_start = accept || (busy_q && more);
  assign busy       = busy_q;
  assign done       = done_q;

  // The first character comes straight from the live inputs so tx can drop on the cycle after start.
  always_comb begin
    sel_idx   = accept ? 3'd0 : char_idx + 3'd1;
    sel_byte  = accept ? data_in : data_q;
    byte_data = ASCII_LF;
`ifdef SBOX_TX_PREFIX_EN
    case (sel_idx)
      3'd0:    byte_data = mode_char(encrypt);
      3'd1:    byte_data = nibble_to_ascii(sel_byte[7:4]);
      3'd2:    byte_data = nibble_to_ascii(sel_byte[3:0]);
      3'd3:    byte_data = ASCII_CR;
      default: byte_data = ASCII_LF;
    endcase
`else
    case (sel_idx)
      3'd0:    byte_data = nibble_to_ascii(sel_byte[7:4]);
      3'd1:    byte_data = nibble_to_ascii(sel_byte[3:0]);
      3'd2:    byte_data = ASCII_CR;
      default: byte_data = ASCII_LF;
    endcase
`endif
  end

`ifndef SBOX_TX_PREFIX_EN
  logic unused_encrypt;
  assign unused_encrypt = encrypt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      char_idx <= '0;
      data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        busy_q   <= 1'b1;
        char_idx <= '0;
        data_q   <= data_in;
      end else begin
        if (busy_q && byte_done) char_idx <= char_idx + 3'd1;
        if (busy_q && byte_ready && !more) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (byte_data),
    .ready (byte_ready),
    .busy  (byte_busy),
    .done  (byte_done),
    .tx    (tx)
  );

endmodule

// File: tb/tb_sbox_uart_tx.sv
// Directed bench for sbox_uart_tx at CLKS_PER_BIT=10; checks tx/busy/done every cycle of each frame.
// Expected character tables follow SBOX_TX_PREFIX_EN when it is defined.
module tb_sbox_uart_tx;

  localparam int CPB = 10;
`ifdef SBOX_TX_PREFIX_EN
  localparam int N_CHARS = 5;
`else
  localparam int N_CHARS = 4;
`endif
  localparam int FRAME_CYC = N_CHARS * 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       encrypt;
  logic       busy, done, tx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_c [5];

  sbox_uart_tx #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data_in(data_in),
    .encrypt(encrypt),
    .busy   (busy),
    .done   (done),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: {tx,busy,done} observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input logic [7:0] c4);
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3; exp_c[4] = c4;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check($sformatf("%s idle %0d", tag, i), {tx, busy, done}, 3'b100);
    end
  endtask

  // Starts a frame on the current negedge and checks every cycle up to the done pulse.
  // pulse_at / zero_at / reset_at are frame cycles for mid-frame disturbances (0 = none).
  task automatic run_frame(input logic [7:0] d, input logic e, input int pulse_at,
                           input int zero_at, input int reset_at);
    int   off, ch, bt;
    logic exp_bit;
    data_in = d;
    encrypt = e;
    start   = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= FRAME_CYC; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      off = cyc - 1;
      ch  = off / (10 * CPB);
      bt  = (off / CPB) % 10;
      if (bt == 0)      exp_bit = 1'b0;
      else if (bt == 9) exp_bit = 1'b1;
      else              exp_bit = exp_c[ch][bt-1];
      check($sformatf("frame %02h char %0d bit %0d cyc %0d", d, ch, bt, cyc),
            {tx, busy, done}, {exp_bit, 2'b10});
      if (cyc == pulse_at) start = 1'b1;
      if (cyc == zero_at)  data_in = 8'h00;
      if (cyc == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check($sformatf("frame %02h abort cyc %0d", d, cyc + 1), {tx, busy, done}, 3'b100);
        reset = 1'b0;
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("frame %02h done cyc %0d", d, FRAME_CYC + 1), {tx, busy, done}, 3'b101);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b1;
    data_in = 8'h63;
    encrypt = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state_with_start_high", {tx, busy, done}, 3'b100);
    reset = 1'b0;
    start = 1'b0;
    idle_check("after_reset", 2);

    // 0x63 -> '6' '3' CR LF
`ifdef SBOX_TX_PREFIX_EN
    set_exp(8'h45, 8'h36, 8'h33, 8'h0D, 8'h0A);
`else
    set_exp(8'h36, 8'h33, 8'h0D, 8'h0A, 8'h00);
`endif
    run_frame(8'h63, 1'b1, 0, 0, 0);
    idle_check("after_63", 3);

    // 0xAF -> 'A' 'F' CR LF
`ifdef SBOX_TX_PREFIX_EN
    set_exp(8'h44, 8'h41, 8'h46, 8'h0D, 8'h0A);
`else
    set_exp(8'h41, 8'h46, 8'h0D, 8'h0A, 8'h00);
`endif
    run_frame(8'hAF, 1'b0, 0, 0, 0);
    idle_check("after_AF", 3);

    // Start re-pulsed at cycle 50 and data_in cleared at 60: frame must still carry 0x63, one done only.
`ifdef SBOX_TX_PREFIX_EN
    set_exp(8'h45, 8'h36, 8'h33, 8'h0D, 8'h0A);
`else
    set_exp(8'h36, 8'h33, 8'h0D, 8'h0A, 8'h00);
`endif
    run_frame(8'h63, 1'b1, 50, 60, 0);
    idle_check("after_ignored_start", 25);

    // Reset at cycle 150 aborts the frame without a done pulse.
`ifdef SBOX_TX_PREFIX_EN
    set_exp(8'h44, 8'h41, 8'h46, 8'h0D, 8'h0A);
`else
    set_exp(8'h41, 8'h46, 8'h0D, 8'h0A, 8'h00);
`endif
    run_frame(8'hAF, 1'b0, 0, 0, 150);
    idle_check("after_abort", 30);

    // Fresh frame after the abort, then a second frame started on its done cycle.
`ifdef SBOX_TX_PREFIX_EN
    set_exp(8'h45, 8'h35, 8'h43, 8'h0D, 8'h0A);
`else
    set_exp(8'h35, 8'h43, 8'h0D, 8'h0A, 8'h00);
`endif
    run_frame(8'h5C, 1'b1, 0, 0, 0);
`ifdef SBOX_TX_PREFIX_EN
    set_exp(8'h44, 8'h39, 8'h45, 8'h0D, 8'h0A);
`else
    set_exp(8'h39, 8'h45, 8'h0D, 8'h0A, 8'h00);
`endif
    run_frame(8'h9E, 1'b0, 0, 0, 0);
    idle_check("after_chain", 3);

    // 0x00 with encrypt=0 -> ('D') '0' '0' CR LF
`ifdef SBOX_TX_PREFIX_EN
    set_exp(8'h44, 8'h30, 8'h30, 8'h0D, 8'h0A);
`else
    set_exp(8'h30, 8'h30, 8'h0D, 8'h0A, 8'h00);
`endif
    run_frame(8'h00, 1'b0, 0, 0, 0);
    idle_check("after_00", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_uart_tx.md
# sbox_uart_tx

Serial transmit path for the S-box demonstrator. It sends the S-box result byte to a host terminal over an 8N1 UART as ASCII hex followed by CR LF, so results can be logged off-board instead of read from LEDR. It sits after the control stage, in parallel with the LED display. `start` is driven from a debounced, edge-detected KEY[1].

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division, 434 at defaults), clocks per UART bit; must be >= 2.

Ports:
- clk  in  1  system clock (CLOCK_50 domain); one clock only.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to transmit one frame.
- data_in  in  8  result byte; sampled only on an accepted start.
- encrypt  in  1  mode tag (1 = forward S-box, 0 = inverse); sampled only on an accepted start.
- busy  out  1  high while a frame is in flight.
- done  out  1  one-cycle pulse when a frame completes.
- tx  out  1  UART line; idle high.

## Operation
- Reset values: tx=1, busy=0, done=0, state IDLE, all counters 0.
- A start in IDLE with busy=0 is accepted: data_in and encrypt are latched. start while busy is ignored, with no queueing.
- Frame characters are sent in this order:
  - High nibble, then low nibble, as uppercase ASCII: 0–9 map to 0x30–0x39, A–F map to 0x41–0x46.
  - Then CR (0x0D), then LF (0x0A).
  - N = 4 characters (5 with the prefix; see Configuration).
- Each character uses 8N1 framing:
  - Start bit 0.
  - 8 data bits, LSB first.
  - Stop bit 1.
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - Characters are back to back, with no idle gap.
- The FSM has four states: IDLE, START, DATA and STOP.
  - IDLE to START on an accepted start.
  - START to DATA when the baud counter reaches CLKS_PER_BIT-1.
  - DATA to STOP after bit 7 is held for a full bit period.
  - STOP to START with the next character, or to IDLE after the last character.
- Counters:
  - The baud counter is $clog2(CLKS_PER_BIT) wide and wraps to 0 at CLKS_PER_BIT-1.
  - The bit index is 3 bits wide.
  - The character index is 3 bits wide and runs 0..N-1.
- Latched data_in and encrypt are stable for the whole frame; input changes mid-frame have no effect.
- Reset mid-frame aborts the frame: the next cycle tx=1 and busy=0, and done is not pulsed.

## Timing
- Cycle 0: start is sampled high.
- Cycle 1: tx=0 (start bit of character 0) and busy=1. All outputs are registered.
- Frame length is N*10*CLKS_PER_BIT cycles, measured from cycle 1.
- At cycle 1+N*10*CLKS_PER_BIT: done=1 for one cycle and busy=0.
- A start on the done cycle is accepted, which gives back-to-back frames with no idle bit.
- Reset takes priority over start in the same cycle.

## Configuration
- SBOX_TX_PREFIX_EN defined:
  - The frame is prefixed with the mode character: 'E' (0x45) if encrypt=1, 'D' (0x44) if encrypt=0.
  - N=5, and the prefix is sent first.
- SBOX_TX_PREFIX_EN undefined: N=4, and encrypt is unused.

## Structure
- Package sbox_pkg holds:
  - The ASCII constants: CR, LF, 'E' and 'D'.
  - The FSM state enum.
  - A function nibble_to_ascii(4-bit) returning 8-bit.
- Sub-module uart_tx_byte:
  - Serializes one byte with a start/busy/done handshake and owns the baud and bit counters.
  - sbox_uart_tx sequences the characters into it, holding the character index and latched data.

## Test plan
All scenarios use CLK_HZ=1000 and BAUD=100, giving CLKS_PER_BIT=10.
- data_in=0x63, start: line carries 0x36, 0x33, 0x0D, 0x0A LSB-first -> tx=0 at cycle 1, done at cycle 401, busy high for cycles 1–400.
- data_in=0xAF -> characters 0x41, 0x46, 0x0D, 0x0A; each bit is held exactly 10 cycles, and stop bits are 1.
- start pulsed again at cycle 50, and data_in changed to 0x00 at cycle 60 -> frame unchanged (0x63 still sent), and only one done pulse.
- Reset at cycle 150 mid-frame -> tx=1 and busy=0 at cycle 151, no done pulse; a new start afterwards sends a complete, correct frame.
- With SBOX_TX_PREFIX_EN defined, encrypt=0 and data_in=0x00 -> characters 0x44, 0x30, 0x30, 0x0D, 0x0A, with done at cycle 501.
- start asserted on the done cycle -> tx=0 on the next cycle, the second frame is correct, and there is no idle bit between frames.
